instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the multicycle MIPS core. Drives the instruction memory read
//  from PC, waits the fixed memory latency, then captures the word into the IR.
//  Advances PC by 4 and splits the IR into OPCODE/RS/RT/Imediato for the
//  field-splitter and control unit downstream. Control may also overwrite PC
//  (branch/jump).
// PARAMETERS
//  MEM_LATENCY  2             cycles from mem_rd sampled to mem_data valid; legal 1..15
//  RESET_PC     32'h00000000  PC value after reset
// PORTS
//  clk          in   1   single clock, rising edge
//  reset_n      in   1   asynchronous active-low reset
//  fetch_start  in   1   control request: fetch instruction at current PC
//  pc_write     in   1   control: load pc_in into PC this edge
//  pc_in        in   32  new PC (branch/jump target)
//  mem_data     in   32  instruction memory read data
//  mem_addr     out  32  instruction memory address (registered)
//  mem_rd       out  1   instruction memory read strobe (registered)
//  fetch_busy   out  1   1 while a fetch is in flight
//  fetch_done   out  1   one-cycle pulse: IR and PC updated this cycle
//  PCOut        out  32  current PC
//  OPCODE       out  6   IR[31:26]
//  RS           out  5   IR[25:21]
//  RT           out  5   IR[20:16]
//  Imediato     out  16  IR[15:0]
// BEHAVIOUR
//  - Clock is clk; reset_n is asynchronous and active-low. While reset_n is low:
//    PCOut=RESET_PC, IR=0, mem_addr=0, mem_rd=0, fetch_busy=0, fetch_done=0,
//    state=IDLE, wait counter=0.
//  - States: IDLE, WAIT, CAPTURE.
//  - IDLE: fetch_start=1 -> next edge: mem_addr<=PCOut, mem_rd<=1,
//    cnt<=MEM_LATENCY-1, fetch_busy<=1, go WAIT.
//  - WAIT: mem_rd<=0 after its one-cycle pulse. cnt decrements each cycle.
//    cnt==0 -> go CAPTURE.
//  - CAPTURE: IR<=mem_data, PCOut<=mem_addr+4 (mod 2^32; 32'hFFFFFFFC wraps
//    to 0), fetch_done<=1 for one cycle, fetch_busy<=0, go IDLE.
//  - Latency: fetch_start sampled at edge 0 -> fetch_done high after edge
//    MEM_LATENCY+1. IR/PCOut are valid in the same cycle fetch_done is high.
//  - Fields are purely combinational from IR. Their reset value is 0.
//  - fetch_start while fetch_busy=1: ignored. No queueing.
//  - fetch_start held high continuously: a new fetch starts on the edge after
//    fetch_done, i.e. back-to-back fetches every MEM_LATENCY+2 cycles.
//  - pc_write in IDLE: PCOut<=pc_in.
//  - pc_write during WAIT: PCOut<=pc_in. The in-flight address is unaffected,
//    since mem_addr is latched.
//  - pc_write in the CAPTURE cycle: pc_in wins over mem_addr+4. IR is still
//    loaded.
//  - pc_write and fetch_start in the same IDLE cycle: the fetch uses the old
//    PCOut; PCOut<=pc_in.
//  - pc_in[1:0] is stored as given. The block does no alignment check.
//  - reset_n asserted mid-fetch: the fetch is aborted immediately. No
//    fetch_done, and all state returns to reset values.
//  - Illegal state encodings recover to IDLE.
// STRUCTURE
//  - Shared package cpu_defs_pkg:
//    - fetch state encoding FS_IDLE/FS_WAIT/FS_CAPTURE (2 bits);
//    - OPCODE field constants (OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03,
//      OP_BEQ=6'h04, OP_LW=6'h23, OP_SW=6'h2B);
//    - field bit positions.
//  - One sub-module: instr_register. It holds the 32-bit IR with load enable and
//    async active-low clear, and does the combinational field split.
//  - FSM, counter and PC register stay in the top module.
// TESTING
//  1. Reset: reset_n low for 3 cycles with RESET_PC=32'h0000_0040
//     -> PCOut=0x40, IR fields 0, mem_rd=0, busy=0.
//  2. Single fetch, MEM_LATENCY=2: PC=0x40, mem_data=0x8C4A0010 (lw) from the
//     memory model, fetch_start pulse
//     -> mem_addr=0x40, mem_rd for 1 cycle, fetch_done 3 cycles after start,
//     OPCODE=0x23, RS=2, RT=10, Imediato=0x0010, PCOut=0x44.
//  3. Branch collision: pc_write=1, pc_in=0x100 in the CAPTURE cycle
//     -> PCOut=0x100 (not 0x44), IR loaded, fetch_done=1.
//  4. Busy ignore + back-to-back: fetch_start held high for 12 cycles,
//     MEM_LATENCY=3 -> fetch_done pulses exactly every 5 cycles.
//     PC sequence 0x0, 0x4, 0x8. Extra start pulses during WAIT cause no
//     extra fetches.
//  5. Wrap: pc_write pc_in=0xFFFFFFFC then fetch -> PCOut=0x00000000 after
//     fetch_done.
//  6. Reset mid-fetch: reset_n low during WAIT -> no fetch_done, PCOut=RESET_PC,
//     IR=0. A fresh fetch after release behaves as in test 2.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle MIPS core.
// Contents:
//   fetch_state_t   2-bit fetch FSM encoding (FS_IDLE / FS_WAIT / FS_CAPTURE)
//   OP_*            primary opcode values seen in IR[31:26]
//   *_MSB / *_LSB   instruction field bit positions
//   PC_STEP         sequential PC increment
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_WAIT    = 2'd1,
    FS_CAPTURE = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/instr_register.sv
// Instruction register with combinational field split.
// Ports:
//   clk       in   1   rising-edge clock
//   reset_n   in   1   asynchronous active-low clear (IR -> 0)
//   load      in   1   capture d into IR this edge
//   d         in   32  instruction word
//   opcode    out  6   IR[31:26]
//   rs        out  5   IR[25:21]
//   rt        out  5   IR[20:16]
//   imm       out  16  IR[15:0]
module instr_register
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [15:0] imm
);

  logic [31:0] ir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir <= '0;
    end else if (load) begin
      ir <= d;
    end
  end

  assign opcode = ir[OPCODE_MSB:OPCODE_LSB];
  assign rs     = ir[RS_MSB:RS_LSB];
  assign rt     = ir[RT_MSB:RT_LSB];
  assign imm    = ir[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle MIPS core: issues a one-cycle read of the
// instruction memory at PC, waits MEM_LATENCY cycles, loads the word into the
// IR and advances PC by 4. Control can overwrite PC at any time (branch/jump).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FS_IDLE    | no fetch in flight; fetch_start launches one
// FS_WAIT    | read issued, counting down the memory latency
// FS_CAPTURE | mem_data valid: load IR, PC <= mem_addr + 4, pulse done
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset_n      in   1   asynchronous active-low reset
//   fetch_start  in   1   request a fetch at current PC (ignored while busy)
//   pc_write     in   1   load pc_in into PC this edge (has priority)
//   pc_in        in   32  branch/jump target
//   mem_data     in   32  instruction memory read data
//   mem_addr     out  32  latched fetch address
//   mem_rd       out  1   one-cycle read strobe
//   fetch_busy   out  1   fetch in flight
//   fetch_done   out  1   one-cycle pulse, IR and PC updated
//   PCOut        out  32  current PC
//   OPCODE/RS/RT/Imediato  IR fields
//
// MEM_LATENCY is legal 1..15 (4-bit wait counter).
module instr_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter int          MEM_LATENCY = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_start,
  input  logic        pc_write,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic [31:0] PCOut,
  output logic [5:0]  OPCODE,
  output logic [4:0]  RS,
  output logic [4:0]  RT,
  output logic [15:0] Imediato
);

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  fetch_state_t state, state_nx;
  logic [3:0]   cnt, cnt_nx;
  logic [31:0]  mem_addr_nx;
  logic [31:0]  pc_nx;
  logic         mem_rd_nx;
  logic         busy_nx;
  logic         done_nx;
  logic         ir_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FS_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    mem_addr_nx = mem_addr;
    mem_rd_nx   = 1'b0;
    busy_nx     = fetch_busy;
    done_nx     = 1'b0;
    pc_nx       = PCOut;
    ir_load     = 1'b0;

    case (state)
      FS_IDLE: begin
        busy_nx = 1'b0;
        if (fetch_start) begin
          // Address is taken from the current PC, so a simultaneous
          // pc_write only affects the next fetch.
          mem_addr_nx = PCOut;
          mem_rd_nx   = 1'b1;
          cnt_nx      = CNT_LOAD;
          busy_nx     = 1'b1;
          state_nx    = FS_WAIT;
        end
      end
      FS_WAIT: begin
        busy_nx = 1'b1;
        if (cnt == 4'd0) begin
          state_nx = FS_CAPTURE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      FS_CAPTURE: begin
        ir_load  = 1'b1;
        pc_nx    = mem_addr + PC_STEP;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = FS_IDLE;
      end
      default: begin
        state_nx = FS_IDLE;
        cnt_nx   = 4'd0;
        busy_nx  = 1'b0;
      end
    endcase

    // A branch/jump target always wins, including over the sequential +4.
    if (pc_write) begin
      pc_nx = pc_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 4'd0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      fetch_busy <= 1'b0;
      fetch_done <= 1'b0;
      PCOut      <= RESET_PC;
    end else begin
      cnt        <= cnt_nx;
      mem_addr   <= mem_addr_nx;
      mem_rd     <= mem_rd_nx;
      fetch_busy <= busy_nx;
      fetch_done <= done_nx;
      PCOut      <= pc_nx;
    end
  end

  instr_register u_ir (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ir_load),
    .d       (mem_data),
    .opcode  (OPCODE),
    .rs      (RS),
    .rt      (RT),
    .imm     (Imediato)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_write = 1'b0;
  logic [31:0] pc_in = '0;

  logic [31:0] mem_data2, mem_addr2, pc2;
  logic        mem_rd2, busy2, done2;
  logic [5:0]  op2;
  logic [4:0]  rs2, rt2;
  logic [15:0] imm2;

  logic [31:0] mem_data3, mem_addr3, pc3;
  logic        mem_rd3, busy3, done3;
  logic [5:0]  op3;
  logic [4:0]  rs3, rt3;
  logic [15:0] imm3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instruction memory model: one lw at 0x40, sw words elsewhere carrying the
  // low address bits in the immediate so each fetch is distinguishable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h8C4A_0010;
    return {6'h2B, 5'd3, 5'd7, a[15:0]};
  endfunction

  assign mem_data2 = mem_word(mem_addr2);
  assign mem_data3 = mem_word(mem_addr3);

  instr_fetch_unit #(.MEM_LATENCY(2), .RESET_PC(32'h0000_0040)) dut2 (
    .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .pc_write(pc_write),
    .pc_in(pc_in), .mem_data(mem_data2), .mem_addr(mem_addr2), .mem_rd(mem_rd2),
    .fetch_busy(busy2), .fetch_done(done2), .PCOut(pc2), .OPCODE(op2), .RS(rs2),
    .RT(rt2), .Imediato(imm2));

  instr_fetch_unit #(.MEM_LATENCY(3), .RESET_PC(32'h0000_0040)) dut3 (
    .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .pc_write(pc_write),
    .pc_in(pc_in), .mem_data(mem_data3), .mem_addr(mem_addr3), .mem_rd(mem_rd3),
    .fetch_busy(busy3), .fetch_done(done3), .PCOut(pc3), .OPCODE(op3), .RS(rs3),
    .RT(rt3), .Imediato(imm3));

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (pc2 !== 32'h40) begin miscompares++; $display("FAIL reset_pc2 got %h want 00000040", pc2); end
    vectors++;
    if (pc3 !== 32'h40) begin miscompares++; $display("FAIL reset_pc3 got %h want 00000040", pc3); end
    vectors++;
    if ({op2, rs2, rt2, imm2} !== 32'h0) begin miscompares++; $display("FAIL reset_fields got %h want 00000000", {op2, rs2, rt2, imm2}); end
    vectors++;
    if ({mem_rd2, busy2, done2} !== 3'b000) begin miscompares++; $display("FAIL reset_ctrl got %b want 000", {mem_rd2, busy2, done2}); end
    vectors++;
    if (mem_addr2 !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got %h want 00000000", mem_addr2); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // dut2 at PC=0x40: lw fetched, done three edges after the start edge.
  task automatic test_single_fetch();
    fetch_start = 1'b1;
    @(negedge clk); // after edge 0
    fetch_start = 1'b0;
    vectors++;
    if (mem_addr2 !== 32'h40) begin miscompares++; $display("FAIL single_mem_addr got %h want 00000040", mem_addr2); end
    vectors++;
    if ({mem_rd2, busy2, done2} !== 3'b110) begin miscompares++; $display("FAIL single_edge0 rd/busy/done got %b want 110", {mem_rd2, busy2, done2}); end
    @(negedge clk); // edge 1
    vectors++;
    if ({mem_rd2, busy2, done2} !== 3'b010) begin miscompares++; $display("FAIL single_edge1 rd/busy/done got %b want 010", {mem_rd2, busy2, done2}); end
    @(negedge clk); // edge 2
    vectors++;
    if ({mem_rd2, busy2, done2} !== 3'b010) begin miscompares++; $display("FAIL single_edge2 rd/busy/done got %b want 010", {mem_rd2, busy2, done2}); end
    @(negedge clk); // edge 3
    vectors++;
    if ({mem_rd2, busy2, done2} !== 3'b001) begin miscompares++; $display("FAIL single_edge3 rd/busy/done got %b want 001", {mem_rd2, busy2, done2}); end
    vectors++;
    if ({op2, rs2, rt2, imm2} !== {6'h23, 5'd2, 5'd10, 16'h0010}) begin
      miscompares++; $display("FAIL single_fields got %h %h %h %h want 23 02 0a 0010", op2, rs2, rt2, imm2);
    end
    vectors++;
    if (pc2 !== 32'h44) begin miscompares++; $display("FAIL single_pc got %h want 00000044", pc2); end
    @(negedge clk); // edge 4
    vectors++;
    if (done2 !== 1'b0) begin miscompares++; $display("FAIL single_done_pulse got %b want 0", done2); end
  endtask

  // dut2 at PC=0x44: pc_write asserted during the CAPTURE cycle.
  task automatic test_branch_collision();
    fetch_start = 1'b1;
    @(negedge clk); // edge 0
    fetch_start = 1'b0;
    @(negedge clk); // edge 1
    @(negedge clk); // edge 2: now in CAPTURE
    pc_write = 1'b1;
    pc_in = 32'h0000_0100;
    @(negedge clk); // edge 3
    pc_write = 1'b0;
    vectors++;
    if (done2 !== 1'b1) begin miscompares++; $display("FAIL branch_done got %b want 1", done2); end
    vectors++;
    if (pc2 !== 32'h100) begin miscompares++; $display("FAIL branch_pc got %h want 00000100", pc2); end
    vectors++;
    if ({op2, imm2} !== {6'h2B, 16'h0044}) begin miscompares++; $display("FAIL branch_ir got %h %h want 2b 0044", op2, imm2); end
  endtask

  // dut3 (latency 3): fetch_start held for 12 edges, fetches at 0, 5, 10.
  task automatic test_back_to_back();
    logic exp_done, exp_rd;
    repeat (6) @(negedge clk);
    pc_write = 1'b1;
    pc_in = 32'h0;
    @(negedge clk);
    pc_write = 1'b0;
    vectors++;
    if (pc3 !== 32'h0) begin miscompares++; $display("FAIL b2b_pc_load got %h want 00000000", pc3); end
    fetch_start = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk); // after edge k
      exp_done = (k == 4) || (k == 9) || (k == 14);
      exp_rd   = (k == 0) || (k == 5) || (k == 10);
      vectors++;
      if ({done3, mem_rd3} !== {exp_done, exp_rd}) begin
        miscompares++; $display("FAIL b2b_edge%0d done/rd got %b%b want %b%b", k, done3, mem_rd3, exp_done, exp_rd);
      end
      if (exp_rd) begin
        vectors++;
        if (mem_addr3 !== 32'(4 * (k / 5))) begin
          miscompares++; $display("FAIL b2b_addr_edge%0d got %h want %h", k, mem_addr3, 32'(4 * (k / 5)));
        end
      end
      if (exp_done) begin
        vectors++;
        if (pc3 !== 32'(4 * (k / 5 + 1)) || imm3 !== 16'(4 * (k / 5))) begin
          miscompares++; $display("FAIL b2b_pc_edge%0d got pc %h imm %h want pc %h imm %h", k, pc3, imm3, 32'(4 * (k / 5 + 1)), 16'(4 * (k / 5)));
        end
      end
      if (k == 11) fetch_start = 1'b0;
    end
  endtask

  task automatic test_wrap();
    int n;
    repeat (4) @(negedge clk);
    pc_write = 1'b1;
    pc_in = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_write = 1'b0;
    vectors++;
    if (pc2 !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc_load got %h want fffffffc", pc2); end
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done2 !== 1'b1) begin
      miscompares++; $display("FAIL wrap_timeout got done %b want 1", done2);
    end else begin
      vectors++;
      if (pc2 !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got %h want 00000000", pc2); end
      vectors++;
      if (mem_addr2 !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr got %h want fffffffc", mem_addr2); end
    end
  endtask

  task automatic test_reset_mid_fetch();
    int seen_done;
    repeat (3) @(negedge clk);
    fetch_start = 1'b1;
    @(negedge clk); // edge 0
    fetch_start = 1'b0;
    @(negedge clk); // edge 1, in WAIT
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy2, mem_rd2, done2} !== 3'b000 || pc2 !== 32'h40) begin
      miscompares++; $display("FAIL midreset_async got busy/rd/done %b pc %h want 000 00000040", {busy2, mem_rd2, done2}, pc2);
    end
    vectors++;
    if ({op2, rs2, rt2, imm2} !== 32'h0) begin miscompares++; $display("FAIL midreset_ir got %h want 00000000", {op2, rs2, rt2, imm2}); end
    seen_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done2 === 1'b1) seen_done++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done2 === 1'b1) seen_done++;
    end
    vectors++;
    if (seen_done != 0 || busy2 !== 1'b0) begin
      miscompares++; $display("FAIL midreset_no_done got %0d pulses busy %b want 0 pulses busy 0", seen_done, busy2);
    end
    test_single_fetch();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_branch_collision();
    test_back_to_back();
    test_wrap();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
